flit_decoder_vc: RTL and testbench
==================================

Name: flit_decoder_vc

Overview:
- Sequential, multi-virtual-channel flit decoder for the router input stage.
- Successor to the combinational head-flit decode:
  - tracks packet framing (head/body/tail) independently per VC;
  - latches route fields from each head flit and tags every following flit of that packet;
  - flags framing errors.
- Sits between input port buffer and route computation; one registered stage with valid/ready on both sides.

Parameters:
- FLIT_WIDTH, 64, total flit width in bits.
- NODE_ID_WIDTH, 8, width of src/dst node id fields.
- COUNT_WIDTH, 8, width of head flit_count field (flits following head).
- NUM_VC, 4, number of virtual channels tracked.
- THIS_NODE_ID, 0, id of this router; dst equal to it sets out_local.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  decoder can accept a flit this cycle.
- in_flit  in  FLIT_WIDTH  raw flit.
- in_vc  in  $clog2(NUM_VC)  VC of in_flit.
- out_valid  out  1  decoded flit valid.
- out_ready  in  1  downstream accepts.
- out_flit  out  FLIT_WIDTH  flit passed through unchanged.
- out_vc  out  $clog2(NUM_VC)  VC of out_flit.
- out_is_head / out_is_tail  out  1 each  framing flags. A single-flit packet asserts both.
- out_src / out_dst  out  NODE_ID_WIDTH each  route fields of the owning packet.
- out_local  out  1  out_dst == THIS_NODE_ID.
- out_err  out  1  framing error on this flit.
- out_err_code  out  2  err_code_t.
- vc_busy  out  NUM_VC  per-VC packet-in-progress.

Behaviour:
- Flit layout:
  - [1:0] type: HEAD=0, BODY=1, TAIL=2, NOPE=3.
  - Head only:
    - [2+:NODE_ID_WIDTH] src;
    - next NODE_ID_WIDTH bits dst;
    - next COUNT_WIDTH bits flit_count.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Transfer on in_valid & in_ready.
  - Latency exactly 1 cycle: outputs registered; they hold stable while out_valid & ~out_ready.
- NOPE flit: consumed, no output produced, no state change.
- Per-VC state: IDLE/BODY, remaining[COUNT_WIDTH], latched src/dst.
- IDLE + HEAD:
  - flit_count==0: emit is_head=1, is_tail=1; stay IDLE.
  - Otherwise: latch src/dst, remaining=flit_count, go BODY; emit is_head=1.
- BODY + BODY:
  - remaining>1: remaining--; emit.
  - remaining==1: emit with err ERR_LONG; remaining stays 1.
- BODY + TAIL:
  - remaining==1: emit is_tail=1, go IDLE.
  - remaining>1: emit is_tail=1, err ERR_EARLY_TAIL, go IDLE.
- BODY + HEAD: emit err ERR_TRUNC; previous packet abandoned; new head processed as in IDLE (relatch, reload).
- IDLE + BODY/TAIL: emit err ERR_ORPHAN, src/dst/local=0, no state change.
- out_src/out_dst/out_local on body/tail flits come from the latched head of that VC. Other VCs are unaffected.
- vc_busy[v]=1 iff VC v in BODY.
- Reset (any time, incl. mid-packet): all VCs IDLE, remaining=0, latches 0, all outputs 0. In-flight output flit is discarded.

Optional Feature:
- FLIT_DECODER_CHECKSUM_EN.
- Defined:
  - head flit top byte [FLIT_WIDTH-1 -: 8] must equal XOR of all other bytes of the flit;
  - on mismatch, head emitted with err ERR_CHECKSUM (code 3, replacing ERR_ORPHAN's slot use) and the VC state is not changed;
  - ERR_ORPHAN then shares code 0 with out_err=1.
- Undefined: no check; code 3 = ERR_ORPHAN.

Decomposition:
- packet_types package:
  - flit_type_t enum;
  - err_code_t (ERR_ORPHAN, ERR_TRUNC, ERR_EARLY_TAIL, ERR_LONG/ERR_CHECKSUM);
  - head field offset constants.
- Sub-module flit_decoder_vc_state: one per VC via generate. Holds state/remaining/latches and computes next state and err.

Test Plan:
- Reset then VC0: HEAD(src=3, dst=0, count=2), BODY, TAIL, out_ready=1 -> 3 outputs at +1 cycle each:
  - head flags 1/0/0, tail 0/0/1;
  - out_src=3, out_local=1 on all;
  - vc_busy[0] 1→0.
- HEAD(count=0) on VC2 -> single output is_head=is_tail=1, vc_busy[2] stays 0.
- Interleave VC0 HEAD(dst=5,count=1), VC1 HEAD(dst=7,count=1), VC0 TAIL, VC1 TAIL -> tails carry dst 5 and 7 respectively, no err.
- Errors:
  - TAIL on idle VC1 -> out_err=1, ERR_ORPHAN;
  - HEAD(count=3)+TAIL -> ERR_EARLY_TAIL;
  - HEAD(count=2)+HEAD -> ERR_TRUNC and new src latched.
- Backpressure: out_ready=0 for 3 cycles with flit held -> in_ready=0, outputs stable; release -> next flit 1 cycle later, no loss/duplication.
- Assert rst mid-packet (VC0 in BODY) -> all outputs 0 immediately; after release, BODY on VC0 gives ERR_ORPHAN.

Source files
------------

// File: rtl/flit_decoder_vc_pkg.sv
// flit_decoder_vc_pkg: flit/VC/error types and head field offsets.
// FLIT_DECODER_CHECKSUM_EN remaps the error codes to make room for ERR_CHECKSUM.
package flit_decoder_vc_pkg;
   typedef enum logic [1:0] {FLIT_HEAD = 2'd0, FLIT_BODY = 2'd1, FLIT_TAIL = 2'd2, FLIT_NOPE = 2'd3} flit_type_t;
   typedef enum logic {VC_IDLE, VC_BODY} vc_state_t;
`ifdef FLIT_DECODER_CHECKSUM_EN
   typedef enum logic [1:0] {ERR_ORPHAN = 2'd0, ERR_TRUNC = 2'd1, ERR_EARLY_TAIL = 2'd2, ERR_CHECKSUM = 2'd3} err_code_t;
   localparam err_code_t ERR_LONG = ERR_ORPHAN;
`else
   typedef enum logic [1:0] {ERR_LONG = 2'd0, ERR_TRUNC = 2'd1, ERR_EARLY_TAIL = 2'd2, ERR_ORPHAN = 2'd3} err_code_t;
   localparam err_code_t ERR_CHECKSUM = ERR_ORPHAN;
`endif
   localparam int TYPE_W = 2;
   localparam int SRC_LSB = TYPE_W;
   function automatic int dst_lsb(input int node_w);
      return SRC_LSB + node_w;
   endfunction
   function automatic int cnt_lsb(input int node_w);
      return SRC_LSB + 2 * node_w;
   endfunction
endpackage

// File: rtl/flit_decoder_vc_if.sv
// flit_decoder_vc_if: input and output flit streams of the decoder.
interface flit_decoder_vc_if #(
   parameter int FLIT_WIDTH    = 64,
   parameter int NODE_ID_WIDTH = 8,
   parameter int NUM_VC        = 4
);
   import flit_decoder_vc_pkg::*;
   localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
   logic                     in_valid;
   logic                     in_ready;
   logic [FLIT_WIDTH-1:0]    in_flit;
   logic [VC_W-1:0]          in_vc;
   logic                     out_valid;
   logic                     out_ready;
   logic [FLIT_WIDTH-1:0]    out_flit;
   logic [VC_W-1:0]          out_vc;
   logic                     out_is_head;
   logic                     out_is_tail;
   logic [NODE_ID_WIDTH-1:0] out_src;
   logic [NODE_ID_WIDTH-1:0] out_dst;
   logic                     out_local;
   logic                     out_err;
   err_code_t                out_err_code;
   modport slave (
      input  in_valid, in_flit, in_vc, out_ready,
      output in_ready, out_valid, out_flit, out_vc, out_is_head, out_is_tail,
             out_src, out_dst, out_local, out_err, out_err_code
   );
   modport master (
      output in_valid, in_flit, in_vc, out_ready,
      input  in_ready, out_valid, out_flit, out_vc, out_is_head, out_is_tail,
             out_src, out_dst, out_local, out_err, out_err_code
   );
endinterface

// File: rtl/flit_decoder_vc_state.sv
// flit_decoder_vc_state: framing state of one VC; decodes the flit routed to it
// and advances only when hit_i marks that flit as consumed.
module flit_decoder_vc_state import flit_decoder_vc_pkg::*; #(
   parameter int NODE_ID_WIDTH = 8,
   parameter int COUNT_WIDTH   = 8,
   parameter int THIS_NODE_ID  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hit_i,
   input  logic                     ck_ok_i,
   input  flit_type_t               type_i,
   input  logic [NODE_ID_WIDTH-1:0] src_i,
   input  logic [NODE_ID_WIDTH-1:0] dst_i,
   input  logic [COUNT_WIDTH-1:0]   cnt_i,
   output logic                     busy_o,
   output logic                     is_head_o,
   output logic                     is_tail_o,
   output logic                     local_o,
   output logic                     err_o,
   output err_code_t                err_code_o,
   output logic [NODE_ID_WIDTH-1:0] src_o,
   output logic [NODE_ID_WIDTH-1:0] dst_o
);
   vc_state_t                state_q, state_d;
   logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
   logic [NODE_ID_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic                     routed;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= VC_IDLE;
         rem_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else if (hit_i) begin
         state_q <= state_d;
         rem_q   <= rem_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
      end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      src_d      = src_q;
      dst_d      = dst_q;
      err_o      = 1'b0;
      err_code_o = err_code_t'(2'd0);
      is_head_o  = type_i == FLIT_HEAD;
      is_tail_o  = type_i == FLIT_TAIL || (is_head_o && cnt_i == '0);
      routed     = is_head_o || state_q == VC_BODY;
      src_o      = is_head_o ? src_i : routed ? src_q : '0;
      dst_o      = is_head_o ? dst_i : routed ? dst_q : '0;
      local_o    = routed && dst_o == NODE_ID_WIDTH'(THIS_NODE_ID);
      if (is_head_o && !ck_ok_i) begin
         err_o      = 1'b1;
         err_code_o = ERR_CHECKSUM;
      end else if (is_head_o) begin
         if (state_q == VC_BODY) begin
            err_o      = 1'b1;
            err_code_o = ERR_TRUNC;
         end
         state_d = cnt_i == '0 ? VC_IDLE : VC_BODY;
         rem_d   = cnt_i;
         if (cnt_i != '0) begin
            src_d = src_i;
            dst_d = dst_i;
         end
      end else if (state_q == VC_IDLE) begin
         err_o      = 1'b1;
         err_code_o = ERR_ORPHAN;
      end else if (is_tail_o) begin
         state_d = VC_IDLE;
         rem_d   = '0;
         if (rem_q > COUNT_WIDTH'(1)) begin
            err_o      = 1'b1;
            err_code_o = ERR_EARLY_TAIL;
         end
      end else if (rem_q > COUNT_WIDTH'(1)) begin
         rem_d = rem_q - 1'b1;
      end else begin
         // Extra body flit: remaining is held at 1 so every further body also flags
         err_o      = 1'b1;
         err_code_o = ERR_LONG;
      end
   end

   assign busy_o = state_q == VC_BODY;
endmodule

// File: rtl/flit_decoder_vc.sv
// flit_decoder_vc: registered per-VC flit framing decoder with valid/ready on both sides.
// Optional head checksum check enabled by defining FLIT_DECODER_CHECKSUM_EN.
module flit_decoder_vc import flit_decoder_vc_pkg::*; #(
   parameter int FLIT_WIDTH    = 64,
   parameter int NODE_ID_WIDTH = 8,
   parameter int COUNT_WIDTH   = 8,
   parameter int NUM_VC        = 4,
   parameter int THIS_NODE_ID  = 0
) (
   input  logic              clk,
   input  logic              rst,
   flit_decoder_vc_if.slave  bus,
   output logic [NUM_VC-1:0] vc_busy
);
   localparam int VC_W    = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
   localparam int DST_LSB = dst_lsb(NODE_ID_WIDTH);
   localparam int CNT_LSB = cnt_lsb(NODE_ID_WIDTH);

   flit_type_t               ftype;
   logic                     accept, emit, ck_ok;
   logic [NUM_VC-1:0]        hit, head_v, tail_v, local_v, err_v;
   err_code_t                code_v [NUM_VC];
   logic [NODE_ID_WIDTH-1:0] src_v [NUM_VC];
   logic [NODE_ID_WIDTH-1:0] dst_v [NUM_VC];

   logic                     out_valid_q, head_q, tail_q, local_q, err_q;
   logic [FLIT_WIDTH-1:0]    flit_q;
   logic [VC_W-1:0]          vc_q;
   logic [NODE_ID_WIDTH-1:0] src_q, dst_q;
   err_code_t                code_q;

   assign ftype        = flit_type_t'(bus.in_flit[TYPE_W-1:0]);
   assign bus.in_ready = ~out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign emit         = accept & (ftype != FLIT_NOPE);

`ifdef FLIT_DECODER_CHECKSUM_EN
   logic [7:0] ck_x;
   always_comb begin
      ck_x = '0;
      for (int i = 0; i < FLIT_WIDTH / 8 - 1; i++) ck_x ^= bus.in_flit[8*i +: 8];
      ck_ok = ck_x == bus.in_flit[FLIT_WIDTH-1 -: 8];
   end
`else
   assign ck_ok = 1'b1;
`endif

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign hit[v] = emit && bus.in_vc == VC_W'(v);
      flit_decoder_vc_state #(
         .NODE_ID_WIDTH (NODE_ID_WIDTH),
         .COUNT_WIDTH   (COUNT_WIDTH),
         .THIS_NODE_ID  (THIS_NODE_ID)
      ) u_state (
         .clk        (clk),
         .rst        (rst),
         .hit_i      (hit[v]),
         .ck_ok_i    (ck_ok),
         .type_i     (ftype),
         .src_i      (bus.in_flit[SRC_LSB +: NODE_ID_WIDTH]),
         .dst_i      (bus.in_flit[DST_LSB +: NODE_ID_WIDTH]),
         .cnt_i      (bus.in_flit[CNT_LSB +: COUNT_WIDTH]),
         .busy_o     (vc_busy[v]),
         .is_head_o  (head_v[v]),
         .is_tail_o  (tail_v[v]),
         .local_o    (local_v[v]),
         .err_o      (err_v[v]),
         .err_code_o (code_v[v]),
         .src_o      (src_v[v]),
         .dst_o      (dst_v[v])
      );
   end

   // Output stage reloads whenever it is empty or being drained; NOPE leaves it empty
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid_q <= 1'b0;
         flit_q      <= '0;
         vc_q        <= '0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         local_q     <= 1'b0;
         err_q       <= 1'b0;
         code_q      <= err_code_t'(2'd0);
      end else if (bus.in_ready) begin
         out_valid_q <= emit;
         if (emit) begin
            flit_q  <= bus.in_flit;
            vc_q    <= bus.in_vc;
            head_q  <= head_v[bus.in_vc];
            tail_q  <= tail_v[bus.in_vc];
            src_q   <= src_v[bus.in_vc];
            dst_q   <= dst_v[bus.in_vc];
            local_q <= local_v[bus.in_vc];
            err_q   <= err_v[bus.in_vc];
            code_q  <= code_v[bus.in_vc];
         end
      end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_flit     = flit_q;
   assign bus.out_vc       = vc_q;
   assign bus.out_is_head  = head_q;
   assign bus.out_is_tail  = tail_q;
   assign bus.out_src      = src_q;
   assign bus.out_dst      = dst_q;
   assign bus.out_local    = local_q;
   assign bus.out_err      = err_q;
   assign bus.out_err_code = code_q;
endmodule

// File: tb/tb_flit_decoder_vc.sv
// tb_flit_decoder_vc: directed and random flit streams against a per-VC packet reference model.
module tb_flit_decoder_vc;
   import flit_decoder_vc_pkg::*;
   localparam int FW = 64, NW = 8, CW = 8, NV = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NV-1:0] vc_busy;
   int            total = 0, bad = 0, rdy_mode = 0;

   typedef struct {
      logic [63:0] flit;
      logic [1:0]  vc;
      logic        head, tail, loc, err;
      logic [1:0]  code;
      logic [7:0]  src, dst;
   } exp_t;

   exp_t       q[$];
   bit         m_busy [NV];
   int         m_rem  [NV];
   logic [7:0] m_src  [NV];
   logic [7:0] m_dst  [NV];

   flit_decoder_vc_if #(.FLIT_WIDTH(FW), .NODE_ID_WIDTH(NW), .NUM_VC(NV)) bus ();

   flit_decoder_vc #(
      .FLIT_WIDTH(FW), .NODE_ID_WIDTH(NW), .COUNT_WIDTH(CW), .NUM_VC(NV), .THIS_NODE_ID(0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .vc_busy (vc_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int t, input int s, input int d, input int c);
      logic [63:0] f = {$urandom, $urandom};
      f[1:0]   = 2'(t);
      f[9:2]   = 8'(s);
      f[17:10] = 8'(d);
      f[25:18] = 8'(c);
      return f;
   endfunction

   function automatic logic [NV-1:0] busy_vec();
      logic [NV-1:0] b;
      for (int i = 0; i < NV; i++) b[i] = m_busy[i];
      return b;
   endfunction

   // Packet-level reference: what the consumed flit must look like downstream
   task automatic model(input logic [63:0] f, input int v);
      exp_t e;
      int t = int'(f[1:0]);
      int c = int'(f[25:18]);
      e = '{flit: f, vc: 2'(v), default: '0};
      e.tail = t == 2;
      if (t == 0) begin
         e.head = 1;
         e.tail = c == 0;
         e.src  = f[9:2];
         e.dst  = f[17:10];
         e.loc  = f[17:10] == 0;
         if (m_busy[v]) begin e.err = 1; e.code = ERR_TRUNC; end
         m_busy[v] = c != 0;
         m_rem[v]  = c;
         if (c != 0) begin m_src[v] = f[9:2]; m_dst[v] = f[17:10]; end
      end else if (!m_busy[v]) begin
         e.err  = 1;
         e.code = ERR_ORPHAN;
      end else begin
         e.src = m_src[v];
         e.dst = m_dst[v];
         e.loc = m_dst[v] == 0;
         if (t == 2) begin
            if (m_rem[v] > 1) begin e.err = 1; e.code = ERR_EARLY_TAIL; end
            m_busy[v] = 0;
         end else if (m_rem[v] > 1) m_rem[v]--;
         else begin e.err = 1; e.code = ERR_LONG; end
      end
      q.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         check("vc_busy", vc_busy, busy_vec());
         check("in_ready", bus.in_ready, q.size() == 0 || bus.out_ready);
         check("out_valid", bus.out_valid, q.size() != 0);
         if (bus.out_valid && q.size() != 0) begin
            e = q[0];
            check("out_flit", bus.out_flit, e.flit);
            check("out_vc", bus.out_vc, e.vc);
            check("out_is_head", bus.out_is_head, e.head);
            check("out_is_tail", bus.out_is_tail, e.tail);
            check("out_src", bus.out_src, e.src);
            check("out_dst", bus.out_dst, e.dst);
            check("out_local", bus.out_local, e.loc);
            check("out_err", bus.out_err, e.err);
            if (e.err) check("out_err_code", bus.out_err_code, e.code);
            if (bus.out_ready) void'(q.pop_front());
         end
         if (bus.in_valid && bus.in_ready && bus.in_flit[1:0] != 2'd3) model(bus.in_flit, int'(bus.in_vc));
      end
   end

   always @(posedge clk) begin
      #1;
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic set_rdy(input int m);
      rdy_mode = m;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [63:0] f, input int v);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_flit  = f;
      bus.in_vc    = v[1:0];
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", n < 100, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int t;
      bus.in_valid = 1'b0;
      bus.in_flit  = '0;
      bus.in_vc    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_flit", bus.out_flit, 0);
      check("rst_vc_busy", vc_busy, 0);
      check("rst_out_err", bus.out_err, 0);
      rst = 1'b0;
      set_rdy(0);
      // Basic three-flit packet on VC0
      send(mk(0, 3, 0, 2), 0);
      check("t1_head", bus.out_is_head, 1);
      check("t1_src", bus.out_src, 3);
      check("t1_local", bus.out_local, 1);
      check("t1_busy", vc_busy[0], 1);
      send(mk(1, 0, 0, 0), 0);
      send(mk(2, 0, 0, 0), 0);
      check("t1_tail", bus.out_is_tail, 1);
      check("t1_tail_src", bus.out_src, 3);
      check("t1_idle", vc_busy[0], 0);
      // Single-flit packet on VC2
      send(mk(0, 1, 9, 0), 2);
      check("t2_head", bus.out_is_head, 1);
      check("t2_tail", bus.out_is_tail, 1);
      check("t2_busy", vc_busy[2], 0);
      // Interleaved packets keep their own route
      send(mk(0, 1, 5, 1), 0);
      send(mk(0, 2, 7, 1), 1);
      send(mk(2, 0, 0, 0), 0);
      check("t3_dst0", bus.out_dst, 5);
      check("t3_err0", bus.out_err, 0);
      send(mk(2, 0, 0, 0), 1);
      check("t3_dst1", bus.out_dst, 7);
      check("t3_err1", bus.out_err, 0);
      // Framing errors
      send(mk(2, 0, 0, 0), 1);
      check("orphan_err", bus.out_err, 1);
      check("orphan_code", bus.out_err_code, ERR_ORPHAN);
      send(mk(0, 4, 4, 3), 3);
      send(mk(2, 0, 0, 0), 3);
      check("early_code", bus.out_err_code, ERR_EARLY_TAIL);
      send(mk(0, 4, 4, 2), 3);
      send(mk(0, 6, 6, 2), 3);
      check("trunc_code", bus.out_err_code, ERR_TRUNC);
      check("trunc_src", bus.out_src, 6);
      send(mk(1, 0, 0, 0), 3);
      check("trunc_relatch", bus.out_src, 6);
      // Backpressure with a flit waiting upstream
      set_rdy(2);
      send(mk(0, 8, 8, 1), 2);
      fork
         send(mk(2, 0, 0, 0), 2);
         begin
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready", bus.in_ready, 0);
               check("bp_held_head", bus.out_is_head, 1);
            end
            set_rdy(0);
         end
      join
      check("bp_tail", bus.out_is_tail, 1);
      check("bp_tail_src", bus.out_src, 8);
      // Reset mid-packet with a flit held in the output stage
      send(mk(0, 3, 3, 3), 0);
      set_rdy(2);
      send(mk(1, 0, 0, 0), 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_flit", bus.out_flit, 0);
      check("mid_rst_busy", vc_busy, 0);
      check("mid_rst_head", bus.out_is_head, 0);
      q.delete();
      for (int i = 0; i < NV; i++) begin
         m_busy[i] = 0;
         m_rem[i]  = 0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_rdy(0);
      send(mk(1, 0, 0, 0), 0);
      check("post_rst_err", bus.out_err, 1);
      check("post_rst_code", bus.out_err_code, ERR_ORPHAN);
      // Random traffic with random backpressure
      set_rdy(1);
      repeat (300) begin
         t = $urandom_range(0, 9);
         send(mk(t < 3 ? 0 : t < 7 ? 1 : t < 9 ? 2 : 3, $urandom_range(0, 255),
                 $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255), $urandom_range(0, 3)),
              $urandom_range(0, NV - 1));
      end
      set_rdy(0);
      repeat (4) @(posedge clk);
      #1;
      check("drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
